// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit with architectural HI/LO.
// Shift-add multiply and restoring divide, one bit per cycle. A finished
// operation writes HI/LO in a final sign-fix cycle and pulses done.
// Latency from the accept edge to done is WIDTH+1 cycles.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-high reset
//   start        request an operation (sampled only in IDLE)
//   op           00 mult, 01 multu, 10 div, 11 divu
//   a, b         multiplicand/dividend, multiplier/divisor
//   mthi, mtlo   write a into HI / LO (IDLE only, start has priority)
//   hi, lo       HI/LO registers
//   busy         operation in flight
//   done         one-cycle pulse when HI/LO carry the new result
//   div_by_zero  last completed divide had b == 0
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic                 r_is_div;
    logic                 r_neg_q;    // product / quotient must be negated
    logic                 r_neg_r;    // remainder takes the dividend's sign
    logic                 r_dz;
    logic [WIDTH-1:0]     r_opnd;     // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   r_acc;      // mult: {product hi, multiplier/lo}; div: {rem, quo}

    // Operand magnitudes for the accept cycle
    logic                 w_signed;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;

    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & a[WIDTH-1];
    assign w_b_neg  = w_signed & b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;

    // One shift-add multiply step; the carry lands in the accumulator MSB
    logic [WIDTH-1:0]     w_add;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_mul_next;

    assign w_add      = r_acc[0] ? r_opnd : '0;
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_add};
    assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

    // One restoring divide step; the remainder is always below the divisor,
    // so the difference and the restored value both fit in WIDTH bits
    logic [WIDTH:0]       w_shift;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_diff;
    logic [2*WIDTH-1:0]   w_div_next;

    assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_opnd});
    assign w_diff     = w_shift[WIDTH-1:0] - r_opnd;
    assign w_div_next = w_ge ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                             : {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    // Sign correction applied in FIX
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    // Control FSM and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_is_div    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dz        <= 1'b0;
            r_opnd      <= '0;
            r_acc       <= '0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_RUN;
                        r_cnt       <= CW'(WIDTH - 1);
                        r_is_div    <= op[1];
                        r_neg_q     <= w_a_neg ^ w_b_neg;
                        r_neg_r     <= w_a_neg;
                        r_dz        <= op[1] & (b == '0);
                        r_opnd      <= op[1] ? w_b_mag : w_a_mag;
                        r_acc       <= op[1] ? {{WIDTH{1'b0}}, w_a_mag}
                                             : {{WIDTH{1'b0}}, w_b_mag};
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                    end else begin
                        if (mthi) hi <= a;
                        if (mtlo) lo <= a;
                    end
                end
                S_RUN: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_FIX: begin
                    if (r_is_div) begin
                        // With a zero divisor the remainder path reproduces a
                        // exactly; only the quotient needs overriding.
                        hi <= w_rem;
                        lo <= r_dz ? '1 : w_quo;
                    end else begin
                        hi <= w_prod[2*WIDTH-1:WIDTH];
                        lo <= w_prod[WIDTH-1:0];
                    end
                    div_by_zero <= r_dz;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (WIDTH = 32).
module tb_mul_div_unit;

    localparam int unsigned W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mthi;
    logic         mtlo;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .hi(hi), .lo(lo), .busy(busy),
        .done(done), .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a start for one cycle; returns 1 time unit after the accept edge
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count edges until done (bounded); cycles = -1 on timeout
    task automatic wait_done(output int cycles, output logic busy_ok);
        busy_ok = busy;
        cycles  = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (done) begin
                cycles = k;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        n_checks++; if (hi !== 32'h0) begin n_errors++; $display("FAIL reset_hi got %h exp %h", hi, 32'h0); end
        n_checks++; if (lo !== 32'h0) begin n_errors++; $display("FAIL reset_lo got %h exp %h", lo, 32'h0); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b exp 0", done); end
        n_checks++; if (div_by_zero !== 1'b0) begin n_errors++; $display("FAIL reset_dbz got %b exp 0", div_by_zero); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mult();
        int   cyc;
        logic bok;
        issue(2'b00, 32'd4, 32'd2);
        wait_done(cyc, bok);
        n_checks++; if (cyc !== 33) begin n_errors++; $display("FAIL mult_latency got %0d exp 33", cyc); end
        n_checks++; if (bok !== 1'b1) begin n_errors++; $display("FAIL mult_busy_during got %b exp 1", bok); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL mult_busy_at_done got %b exp 0", busy); end
        n_checks++; if (hi !== 32'h0) begin n_errors++; $display("FAIL mult_4x2_hi got %h exp %h", hi, 32'h0); end
        n_checks++; if (lo !== 32'h8) begin n_errors++; $display("FAIL mult_4x2_lo got %h exp %h", lo, 32'h8); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL done_one_cycle got %b exp 0", done); end

        issue(2'b00, 32'hFFFF_FFFD, 32'd5);
        wait_done(cyc, bok);
        n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL mult_neg_hi got %h exp %h", hi, 32'hFFFF_FFFF); end
        n_checks++; if (lo !== 32'hFFFF_FFF1) begin n_errors++; $display("FAIL mult_neg_lo got %h exp %h", lo, 32'hFFFF_FFF1); end

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(cyc, bok);
        n_checks++; if (hi !== 32'hFFFF_FFFE) begin n_errors++; $display("FAIL multu_max_hi got %h exp %h", hi, 32'hFFFF_FFFE); end
        n_checks++; if (lo !== 32'h0000_0001) begin n_errors++; $display("FAIL multu_max_lo got %h exp %h", lo, 32'h1); end
    endtask

    task automatic test_div();
        int   cyc;
        logic bok;
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc, bok);
        n_checks++; if (cyc !== 33) begin n_errors++; $display("FAIL div_latency got %0d exp 33", cyc); end
        n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_errors++; $display("FAIL div_neg7_lo got %h exp %h", lo, 32'hFFFF_FFFD); end
        n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL div_neg7_hi got %h exp %h", hi, 32'hFFFF_FFFF); end

        issue(2'b10, 32'd7, 32'hFFFF_FFFE);
        wait_done(cyc, bok);
        n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_errors++; $display("FAIL div_negdiv_lo got %h exp %h", lo, 32'hFFFF_FFFD); end
        n_checks++; if (hi !== 32'h1) begin n_errors++; $display("FAIL div_negdiv_hi got %h exp %h", hi, 32'h1); end

        issue(2'b11, 32'd7, 32'd2);
        wait_done(cyc, bok);
        n_checks++; if (lo !== 32'h3) begin n_errors++; $display("FAIL divu_lo got %h exp %h", lo, 32'h3); end
        n_checks++; if (hi !== 32'h1) begin n_errors++; $display("FAIL divu_hi got %h exp %h", hi, 32'h1); end

        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc, bok);
        n_checks++; if (lo !== 32'h8000_0000) begin n_errors++; $display("FAIL div_ovf_lo got %h exp %h", lo, 32'h8000_0000); end
        n_checks++; if (hi !== 32'h0) begin n_errors++; $display("FAIL div_ovf_hi got %h exp %h", hi, 32'h0); end
        n_checks++; if (div_by_zero !== 1'b0) begin n_errors++; $display("FAIL div_ovf_dbz got %b exp 0", div_by_zero); end
    endtask

    task automatic test_div_zero();
        int   cyc;
        logic bok;
        issue(2'b11, 32'd7, 32'd0);
        wait_done(cyc, bok);
        n_checks++; if (cyc !== 33) begin n_errors++; $display("FAIL dz_latency got %0d exp 33", cyc); end
        n_checks++; if (hi !== 32'h7) begin n_errors++; $display("FAIL dz_u_hi got %h exp %h", hi, 32'h7); end
        n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL dz_u_lo got %h exp %h", lo, 32'hFFFF_FFFF); end
        n_checks++; if (div_by_zero !== 1'b1) begin n_errors++; $display("FAIL dz_u_flag got %b exp 1", div_by_zero); end

        issue(2'b10, 32'hFFFF_FFF9, 32'd0);
        wait_done(cyc, bok);
        n_checks++; if (hi !== 32'hFFFF_FFF9) begin n_errors++; $display("FAIL dz_s_hi got %h exp %h", hi, 32'hFFFF_FFF9); end
        n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL dz_s_lo got %h exp %h", lo, 32'hFFFF_FFFF); end
        n_checks++; if (div_by_zero !== 1'b1) begin n_errors++; $display("FAIL dz_s_flag got %b exp 1", div_by_zero); end

        // Flag holds in IDLE and clears on the next accept edge
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (div_by_zero !== 1'b1) begin n_errors++; $display("FAIL dz_hold got %b exp 1", div_by_zero); end
        issue(2'b00, 32'd3, 32'd3);
        n_checks++; if (div_by_zero !== 1'b0) begin n_errors++; $display("FAIL dz_clear got %b exp 0", div_by_zero); end
        wait_done(cyc, bok);
        n_checks++; if (lo !== 32'd9) begin n_errors++; $display("FAIL dz_next_mult_lo got %h exp %h", lo, 32'd9); end
    endtask

    task automatic test_back_to_back();
        int   cyc;
        logic bok;
        issue(2'b00, 32'd4, 32'd2);
        wait_done(cyc, bok);
        // still inside the done cycle: start again right away
        issue(2'b11, 32'd100, 32'd7);
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL b2b_accept_busy got %b exp 1", busy); end
        wait_done(cyc, bok);
        n_checks++; if (cyc !== 33) begin n_errors++; $display("FAIL b2b_latency got %0d exp 33", cyc); end
        n_checks++; if (lo !== 32'd14) begin n_errors++; $display("FAIL b2b_lo got %h exp %h", lo, 32'd14); end
        n_checks++; if (hi !== 32'd2) begin n_errors++; $display("FAIL b2b_hi got %h exp %h", hi, 32'd2); end
    endtask

    task automatic test_busy_ignore();
        int   cyc;
        logic bok;
        int   extra;
        issue(2'b00, 32'd6, 32'd7);
        repeat (5) @(posedge clk);
        @(negedge clk);
        op = 2'b11; a = 32'd100; b = 32'd3; start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        wait_done(cyc, bok);
        n_checks++; if (cyc !== 27) begin n_errors++; $display("FAIL busy_ign_latency got %0d exp 27", cyc); end
        n_checks++; if (hi !== 32'h0) begin n_errors++; $display("FAIL busy_ign_hi got %h exp %h", hi, 32'h0); end
        n_checks++; if (lo !== 32'd42) begin n_errors++; $display("FAIL busy_ign_lo got %h exp %h", lo, 32'd42); end
        extra = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        n_checks++; if (extra !== 0) begin n_errors++; $display("FAIL busy_ign_extra_done got %0d exp 0", extra); end
        n_checks++; if (lo !== 32'd42) begin n_errors++; $display("FAIL busy_ign_lo_after got %h exp %h", lo, 32'd42); end
    endtask

    task automatic test_mthi_mtlo();
        int   cyc;
        logic bok;
        @(negedge clk);
        a = 32'h1234_5678; mthi = 1'b1;
        @(posedge clk); #1;
        mthi = 1'b0;
        n_checks++; if (hi !== 32'h1234_5678) begin n_errors++; $display("FAIL mthi_hi got %h exp %h", hi, 32'h1234_5678); end
        @(negedge clk);
        a = 32'h9; mtlo = 1'b1;
        @(posedge clk); #1;
        mtlo = 1'b0;
        n_checks++; if (lo !== 32'h9) begin n_errors++; $display("FAIL mtlo_lo got %h exp %h", lo, 32'h9); end
        n_checks++; if (hi !== 32'h1234_5678) begin n_errors++; $display("FAIL mtlo_hi_kept got %h exp %h", hi, 32'h1234_5678); end
        @(negedge clk);
        a = 32'hA5A5_A5A5; mthi = 1'b1; mtlo = 1'b1;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        n_checks++; if (hi !== 32'hA5A5_A5A5) begin n_errors++; $display("FAIL mthilo_hi got %h exp %h", hi, 32'hA5A5_A5A5); end
        n_checks++; if (lo !== 32'hA5A5_A5A5) begin n_errors++; $display("FAIL mthilo_lo got %h exp %h", lo, 32'hA5A5_A5A5); end

        // start wins over mtlo in the same cycle
        @(negedge clk);
        op = 2'b01; a = 32'd3; b = 32'd5; start = 1'b1; mtlo = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mtlo = 1'b0;
        n_checks++; if (lo !== 32'hA5A5_A5A5) begin n_errors++; $display("FAIL start_mtlo_drop got %h exp %h", lo, 32'hA5A5_A5A5); end
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL start_mtlo_busy got %b exp 1", busy); end
        wait_done(cyc, bok);
        n_checks++; if (lo !== 32'd15) begin n_errors++; $display("FAIL start_mtlo_lo got %h exp %h", lo, 32'd15); end
        n_checks++; if (hi !== 32'd0) begin n_errors++; $display("FAIL start_mtlo_hi got %h exp %h", hi, 32'd0); end
    endtask

    task automatic test_reset_mid();
        int   cyc;
        logic bok;
        int   extra;
        @(negedge clk);
        a = 32'hDEAD_BEEF; mthi = 1'b1; mtlo = 1'b1;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        issue(2'b10, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (hi !== 32'h0) begin n_errors++; $display("FAIL rst_mid_hi got %h exp %h", hi, 32'h0); end
        n_checks++; if (lo !== 32'h0) begin n_errors++; $display("FAIL rst_mid_lo got %h exp %h", lo, 32'h0); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL rst_mid_done got %b exp 0", done); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        extra = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        n_checks++; if (extra !== 0) begin n_errors++; $display("FAIL rst_mid_no_done got %0d exp 0", extra); end
        issue(2'b00, 32'd4, 32'd2);
        wait_done(cyc, bok);
        n_checks++; if (cyc !== 33) begin n_errors++; $display("FAIL rst_after_latency got %0d exp 33", cyc); end
        n_checks++; if (lo !== 32'd8) begin n_errors++; $display("FAIL rst_after_lo got %h exp %h", lo, 32'd8); end
        n_checks++; if (hi !== 32'd0) begin n_errors++; $display("FAIL rst_after_hi got %h exp %h", hi, 32'd0); end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_busy_ignore();
        test_mthi_mtlo();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS datapath. Executes signed and unsigned multiply and divide by iterative shift-add and restoring division, one bit per cycle. Sits beside the ALU in the execute stage; the controller issues with `start`, stalls on `busy`, and reads results through `hi`/`lo` (mfhi/mflo). Also supports direct HI/LO writes for mthi/mtlo.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits; legal range ≥ 2.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `start` input 1: request an operation; sampled only in IDLE.
- `op` input 2: 00 mult, 01 multu, 10 div, 11 divu.
- `a` input WIDTH: multiplicand / dividend (rs).
- `b` input WIDTH: multiplier / divisor (rt).
- `mthi` input 1: write `a` into HI; honoured only in IDLE.
- `mtlo` input 1: write `a` into LO; honoured only in IDLE.
- `hi` output WIDTH: HI register (product upper half / remainder).
- `lo` output WIDTH: LO register (product lower half / quotient).
- `busy` output 1: operation in flight; new start and mthi/mtlo ignored.
- `done` output 1: one-cycle pulse; HI/LO hold the new result.
- `div_by_zero` output 1: last completed div/divu had `b == 0`; held until the next accepted start.

## Operation
- States: IDLE, RUN, FIX.
- IDLE: on `start`, latch `op` and operand magnitudes (absolute value for signed ops; raw for unsigned), record the result signs, load the iteration counter to `WIDTH-1`, clear `div_by_zero`, and go to RUN. `start` has priority over `mthi`/`mtlo` in the same cycle; those writes are dropped.
- IDLE without `start`: `mthi` loads HI from `a` and `mtlo` loads LO from `a`. Both may be asserted together.
- RUN: perform one iteration per cycle. Multiply: conditional add of the multiplicand, then shift the 2·WIDTH accumulator right. Divide: shift the remainder left, trial-subtract the divisor, set the quotient bit when the result is non-negative, and restore otherwise. Decrement the counter; at 0 go to FIX.
- FIX: apply sign correction and write HI/LO. Pulse `done`, then return to IDLE.
  - mult: negate the 2·WIDTH product if the operand signs differ.
  - div: negate the quotient if the operand signs differ. The remainder takes the sign of the dividend.
- Divide by zero (`b == 0`, div or divu): latency is unchanged. Result is HI = `a`, LO = all ones, for both signed and unsigned. `div_by_zero` = 1 together with `done`.
- Signed overflow, div of most-negative by −1: LO = most-negative value (wraps), HI = 0. No flag is raised.
- HI/LO are never partially updated; they change only in FIX, on mthi/mtlo, or on reset.
- `start`, `mthi` and `mtlo` while `busy`: ignored, with no effect on state or outputs.

## Timing
- Reset values: HI = 0, LO = 0, `busy` = 0, `done` = 0, `div_by_zero` = 0, state IDLE, counter 0.
- Reset asserted mid-operation aborts immediately. HI/LO are cleared, not the previous values.
- Accept edge E0 (start sampled in IDLE). `busy` = 1 from after E0 through the cycle before FIX completes.
- Iterations occur on edges E1..E_WIDTH. FIX writes on edge E_(WIDTH+1).
- After E_(WIDTH+1): `done` = 1 for exactly one cycle, `busy` = 0, new HI/LO visible. Latency is WIDTH+1 cycles (33 for WIDTH = 32).
- Back-to-back operation: `start` may be asserted in the cycle where `done` = 1. It is accepted on that edge, so the next `done` comes WIDTH+1 cycles later.
- mthi/mtlo: HI/LO update one edge after the write is sampled.
- `done`, `busy` and `div_by_zero` are registered outputs; no combinational path from inputs to outputs.

## Test plan
- mult a=4, b=2 -> `done` 33 cycles after start, HI = 00000000, LO = 00000008; `busy` high for the cycles between.
- mult a=FFFFFFFD (−3), b=5 -> HI = FFFFFFFF, LO = FFFFFFF1. multu a=b=FFFFFFFF -> HI = FFFFFFFE, LO = 00000001.
- div a=FFFFFFF9 (−7), b=2 -> LO = FFFFFFFD, HI = FFFFFFFF. divu a=7, b=2 -> LO = 3, HI = 1. div a=80000000, b=FFFFFFFF -> LO = 80000000, HI = 0.
- divu a=7, b=0 -> HI = 00000007, LO = FFFFFFFF, `div_by_zero` = 1 with `done`. A following mult clears `div_by_zero` on its accept edge.
- During busy: pulse `start` with new operands and pulse `mthi`/`mtlo` -> result equals the first operation, and exactly one `done`. In IDLE, mthi a=12345678 then mtlo a=9 -> HI = 12345678, LO = 9. With `start` and `mtlo` in the same cycle -> only the operation result is written.
- Assert `reset` 10 cycles into a div -> outputs go to reset values immediately with no `done`. After release, a mult 4×2 completes normally with LO = 8.
